// File: rtl/rsa_pkg.sv
// Shared types and constants for the 8-bit Montgomery modexp engine.
package rsa_pkg;

    localparam int RSA_WIDTH = 8;
    localparam int MM_CYCLES = 9;
    localparam int NUM_MM    = 19;

    typedef enum logic [2:0] {
        IDLE,
        PRE_M,
        PRE_X,
        SQR,
        MUL,
        POST
    } state_t;

endpackage

// File: rtl/rsa_modexp_engine_mont_mul.sv
// Radix-2 bit-serial Montgomery multiplier: res = a*b*R^-1 mod n.
// Fixed latency of MM_CYCLES edges from the edge that samples go.
module mont_mul
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] res,
    output logic             rdy
);

    localparam int CW = $clog2(MM_CYCLES);
    localparam int JW = $clog2(WIDTH);

    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH+1:0] r_s;

    logic [JW-1:0]    w_j;
    logic [WIDTH+1:0] w_acc;
    logic [WIDTH+1:0] w_odd;
    logic [WIDTH+1:0] w_next;
    logic             w_last;

    // The go edge itself performs iteration 0, starting from S = 0.
    assign w_j    = r_busy ? r_cnt[JW-1:0] : '0;
    assign w_acc  = (r_busy ? r_s : '0) + (a[w_j] ? {2'b00, b} : '0);
    assign w_odd  = w_acc + (w_acc[0] ? {2'b00, n} : '0);
    assign w_next = w_odd >> 1;
    assign w_last = r_busy && (r_cnt == CW'(MM_CYCLES - 1));

    assign rdy = w_last;
    assign res = (r_s >= {2'b00, n}) ? (r_s[WIDTH-1:0] - n)
                                     : r_s[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_s    <= '0;
        end else if (!r_busy) begin
            if (go) begin
                r_busy <= 1'b1;
                r_cnt  <= CW'(1);
                r_s    <= w_next;
            end
        end else if (w_last) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_s   <= w_next;
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/rsa_modexp_engine.sv
// Constant-time left-to-right modexp: result = m^e mod n over 19 Montgomery
// products; latency does not depend on the exponent value.
module rsa_modexp_engine
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] plain_text,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    input  logic [WIDTH-1:0] mont_const,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             err,
    output logic             busy
);

    localparam int JW = $clog2(WIDTH);

    state_t           r_state;
    logic             r_start_q;
    logic             r_go;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_e;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_c;
    logic [WIDTH-1:0] r_mb;
    logic [WIDTH-1:0] r_x;
    logic [JW-1:0]    r_bit;

    logic             w_accept;
    logic             w_mm_rst;
    logic             w_rdy;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_res;

    assign w_accept = start && !r_start_q && !r_busy && !stop;
    assign w_mm_rst = rst || stop;

    assign result = r_result;
    assign done   = r_done;
    assign err    = r_err;
    assign busy   = r_busy;

    always_comb begin
        w_a = '0;
        w_b = '0;
        unique case (r_state)
            PRE_M: begin w_a = r_m;        w_b = r_c;        end
            PRE_X: begin w_a = WIDTH'(1);  w_b = r_c;        end
            SQR:   begin w_a = r_x;        w_b = r_x;        end
            MUL:   begin w_a = r_x;        w_b = r_mb;       end
            POST:  begin w_a = r_x;        w_b = WIDTH'(1);  end
            default: ;
        endcase
    end

    mont_mul #(.WIDTH(WIDTH)) u_mm (
        .clk (clk),
        .rst (w_mm_rst),
        .go  (r_go),
        .a   (w_a),
        .b   (w_b),
        .n   (r_n),
        .res (w_res),
        .rdy (w_rdy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_start_q <= 1'b0;
            r_go      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_result  <= '0;
            r_m       <= '0;
            r_e       <= '0;
            r_n       <= '0;
            r_c       <= '0;
            r_mb      <= '0;
            r_x       <= '0;
            r_bit     <= '0;
        end else begin
            r_start_q <= start;
            r_go      <= 1'b0;
            if (stop) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
            end else if (w_accept) begin
                r_m    <= plain_text;
                r_e    <= exponent;
                r_n    <= modulus;
                r_c    <= mont_const;
                r_done <= 1'b0;
                r_err  <= 1'b0;
                if (!modulus[0]) begin
                    r_err    <= 1'b1;
                    r_done   <= 1'b1;
                    r_result <= '0;
                end else begin
                    r_state <= PRE_M;
                    r_busy  <= 1'b1;
                    r_go    <= 1'b1;
                end
            end else if (w_rdy) begin
                unique case (r_state)
                    PRE_M: begin
                        r_mb    <= w_res;
                        r_state <= PRE_X;
                        r_go    <= 1'b1;
                    end
                    PRE_X: begin
                        r_x     <= w_res;
                        r_bit   <= JW'(WIDTH - 1);
                        r_state <= SQR;
                        r_go    <= 1'b1;
                    end
                    SQR: begin
                        r_x     <= w_res;
                        r_state <= MUL;
                        r_go    <= 1'b1;
                    end
                    // Product always computed; only the write is conditional.
                    MUL: begin
                        if (r_e[r_bit]) r_x <= w_res;
                        r_go <= 1'b1;
                        if (r_bit == '0) begin
                            r_state <= POST;
                        end else begin
                            r_bit   <= r_bit - JW'(1);
                            r_state <= SQR;
                        end
                    end
                    POST: begin
                        r_result <= w_res;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Directed bench for rsa_modexp_engine with hand-computed RSA vectors.
module tb_rsa_modexp_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic [7:0] pt;
    logic [7:0] ex;
    logic [7:0] md;
    logic [7:0] mc;
    logic [7:0] result;
    logic       done;
    logic       err;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    rsa_modexp_engine #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .plain_text (pt),
        .exponent   (ex),
        .modulus    (md),
        .mont_const (mc),
        .result     (result),
        .done       (done),
        .err        (err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic set_ops(input logic [7:0] m, input logic [7:0] e,
                           input logic [7:0] n, input logic [7:0] c);
        pt = m;
        ex = e;
        md = n;
        mc = c;
    endtask

    // One pulsed start; checks exact 171-cycle latency and the result.
    task automatic run_op(input string tag, input logic [7:0] m,
                          input logic [7:0] e, input logic [7:0] n,
                          input logic [7:0] c, input logic [7:0] exp_r);
        start = 1'b0;
        tick();
        set_ops(m, e, n, c);
        start = 1'b1;
        tick();
        chk({tag, "_busy_k"}, 32'(busy), 32'd1);
        chk({tag, "_done_k"}, 32'(done), 32'd0);
        start = 1'b0;
        repeat (170) tick();
        chk({tag, "_done_170"}, 32'(done), 32'd0);
        tick();
        chk({tag, "_done_171"}, 32'(done), 32'd1);
        chk({tag, "_busy_171"}, 32'(busy), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'(exp_r));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        set_ops(8'd0, 8'd0, 8'd1, 8'd0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        run_op("enc88", 8'd88, 8'd7, 8'd187, 8'd86, 8'd11);

        // Held-high start must not retrigger after completion.
        tick();
        set_ops(8'd11, 8'd23, 8'd187, 8'd86);
        start = 1'b1;
        tick();
        chk("dec_busy_k", 32'(busy), 32'd1);
        repeat (171) tick();
        chk("dec_result", 32'(result), 32'd88);
        chk("dec_done", 32'(done), 32'd1);
        repeat (5) tick();
        chk("held_busy", 32'(busy), 32'd0);
        chk("held_done", 32'(done), 32'd1);
        start = 1'b0;

        run_op("e0", 8'd5, 8'd0, 8'd187, 8'd86, 8'd1);
        run_op("n1", 8'd5, 8'd3, 8'd1, 8'd0, 8'd0);
        run_op("m200", 8'd200, 8'd1, 8'd187, 8'd86, 8'd13);

        // Even modulus: reject in one cycle, busy never rises.
        tick();
        set_ops(8'd9, 8'd3, 8'd186, 8'd86);
        start = 1'b1;
        tick();
        chk("even_err", 32'(err), 32'd1);
        chk("even_done", 32'(done), 32'd1);
        chk("even_result", 32'(result), 32'd0);
        chk("even_busy", 32'(busy), 32'd0);
        tick();
        chk("even_busy2", 32'(busy), 32'd0);
        start = 1'b0;
        tick();
        set_ops(8'd88, 8'd7, 8'd187, 8'd86);
        start = 1'b1;
        tick();
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_done", 32'(done), 32'd0);
        start = 1'b0;
        repeat (171) tick();
        chk("clr_result", 32'(result), 32'd11);

        // Stop at cycle 50 keeps the previous result.
        tick();
        set_ops(8'd11, 8'd23, 8'd187, 8'd86);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (49) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_done", 32'(done), 32'd0);
        chk("stop_result", 32'(result), 32'd11);
        chk("stop_err", 32'(err), 32'd0);

        // Operand changes and a start edge mid-run are both ignored.
        tick();
        set_ops(8'd11, 8'd23, 8'd187, 8'd86);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        set_ops(8'd88, 8'd7, 8'd185, 8'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (159) tick();
        chk("mid_busy_170", 32'(busy), 32'd1);
        tick();
        chk("mid_result", 32'(result), 32'd88);
        chk("mid_done", 32'(done), 32'd1);
        repeat (3) tick();
        chk("mid_noqueue", 32'(busy), 32'd0);

        // Reset at cycle 100 clears everything next edge.
        tick();
        set_ops(8'd88, 8'd7, 8'd187, 8'd86);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (99) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_result", 32'(result), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_err", 32'(err), 32'd0);
        run_op("post_rst", 8'd88, 8'd7, 8'd187, 8'd86, 8'd11);

        // Stop and start together: stop wins, nothing starts.
        tick();
        stop  = 1'b1;
        start = 1'b1;
        tick();
        chk("ss_busy", 32'(busy), 32'd0);
        chk("ss_done", 32'(done), 32'd0);
        stop = 1'b0;
        tick();
        chk("ss_busy2", 32'(busy), 32'd0);
        chk("ss_result", 32'(result), 32'd11);
        start = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
